// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access path.
package mem_pkg;

  // Access size encodings carried on MuxLoad_in (2'b11 is treated as word)
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Bus transaction controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for data-memory accesses: alignment check, byte enables and
// store replication for the incoming access, and sign-extending lane
// extraction for the read word of the access in flight.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  acc_size,
  input  logic [1:0]  acc_addr_lo,
  input  logic [31:0] st_data,
  output logic        aligned,
  output logic [3:0]  byte_en,
  output logic [31:0] st_data_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rd_word,
  output logic [31:0] ld_data
);

  // Store side: alignment, byte enables and lane-replicated data
  always_comb begin
    aligned     = 1'b1;
    byte_en     = '0;
    st_data_rep = '0;
    case (acc_size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << acc_addr_lo;
        st_data_rep = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        aligned     = ~acc_addr_lo[0];
        byte_en     = acc_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data_rep = {2{st_data[15:0]}};
      end
      default: begin
        aligned     = (acc_addr_lo == 2'b00);
        byte_en     = 4'b1111;
        st_data_rep = st_data;
      end
    endcase
  end

  // Load side: pick the addressed lane and sign-extend it
  always_comb begin
    ld_data = rd_word;
    case (ld_size)
      SZ_BYTE: begin
        case (ld_addr_lo)
          2'd0:    ld_data = sext8(rd_word[7:0]);
          2'd1:    ld_data = sext8(rd_word[15:8]);
          2'd2:    ld_data = sext8(rd_word[23:16]);
          default: ld_data = sext8(rd_word[31:24]);
        endcase
      end
      SZ_HALF: ld_data = ld_addr_lo[1] ? sext16(rd_word[31:16]) : sext16(rd_word[15:0]);
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: runs a req/ack bus transaction
// for each aligned load/store, stalls the pipeline while it is outstanding,
// flags misaligned accesses and abandons transactions that time out.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MuxLoad_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] Rt_in,
  output logic        Stall,
  output logic [31:0] ReadData_out,
  output logic        AccessDone,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBE,
  output logic [31:0] DMemWData,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    size_q;
  logic [1:0]    addr_lo_q;
  logic          access;
  logic          aligned;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [31:0]   ld_data;

  assign access = MemRead_in | MemWrite_in;

  mem_lane_align u_lane (
    .acc_size    (MuxLoad_in),
    .acc_addr_lo (ALUResult_in[1:0]),
    .st_data     (Rt_in),
    .aligned     (aligned),
    .byte_en     (be_n),
    .st_data_rep (wdata_n),
    .ld_size     (size_q),
    .ld_addr_lo  (addr_lo_q),
    .rd_word     (DMemRData),
    .ld_data     (ld_data)
  );

  // Stall is gated by reset so it drops with the asynchronous clear even
  // while EX/MEM still presents the access.
  assign Stall = Rst & (((state == S_IDLE) & access & aligned) | (state == S_REQ));

  // Transaction FSM, timeout counter, latched bus fields and pulse outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      size_q       <= '0;
      addr_lo_q    <= '0;
      ReadData_out <= '0;
      AccessDone   <= 1'b0;
      AlignErr     <= 1'b0;
      BusErr       <= 1'b0;
      DMemReq      <= 1'b0;
      DMemWe       <= 1'b0;
      DMemAddr     <= '0;
      DMemBE       <= '0;
      DMemWData    <= '0;
    end else begin
      AccessDone <= 1'b0;
      AlignErr   <= 1'b0;
      BusErr     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (!aligned) begin
              AlignErr <= 1'b1;
            end else begin
              size_q    <= MuxLoad_in;
              addr_lo_q <= ALUResult_in[1:0];
              DMemAddr  <= {ALUResult_in[31:2], 2'b00};
              DMemWe    <= MemWrite_in;
              DMemBE    <= be_n;
              DMemWData <= wdata_n;
              DMemReq   <= 1'b1;
              cnt       <= '0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (DMemAck) begin
            if (!DMemWe) ReadData_out <= ld_data;
            DMemReq    <= 1'b0;
            AccessDone <= 1'b1;
            state      <= S_DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            DMemReq    <= 1'b0;
            AccessDone <= 1'b1;
            BusErr     <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load/store vectors with a read-data
// scoreboard, plus hand sequences for reset behaviour.
module tb_mem_access_unit;

  localparam int unsigned TO = 15;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead_in, MemWrite_in;
  logic [1:0]  MuxLoad_in;
  logic [31:0] ALUResult_in, Rt_in;
  logic        Stall, AccessDone, AlignErr, BusErr;
  logic [31:0] ReadData_out;
  logic        DMemReq, DMemWe, DMemAck;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBE;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] sb_q[$];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MuxLoad_in(MuxLoad_in),
    .ALUResult_in(ALUResult_in), .Rt_in(Rt_in),
    .Stall(Stall), .ReadData_out(ReadData_out), .AccessDone(AccessDone),
    .AlignErr(AlignErr), .BusErr(BusErr),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBE(DMemBE),
    .DMemWData(DMemWData), .DMemAck(DMemAck), .DMemRData(DMemRData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned ack_at;     // REQ cycle (1-based) carrying the ack; 0 = never
    logic        exp_align;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_read;   // ReadData_out after this access
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    MemRead_in   = 1'b0;
    MemWrite_in  = 1'b0;
    MuxLoad_in   = 2'b00;
    ALUResult_in = '0;
    Rt_in        = '0;
    DMemAck      = 1'b0;
    DMemRData    = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned k;
    int unsigned stalls;
    int unsigned exp_stalls;
    bit          done;
    logic [31:0] exp_rd;
    @(negedge Clk);
    MemRead_in   = v.rd;
    MemWrite_in  = v.wr;
    MuxLoad_in   = v.size;
    ALUResult_in = v.addr;
    Rt_in        = v.wdata;
    DMemAck      = 1'b0;
    DMemRData    = '0;
    #1;
    chk($sformatf("v%0d stall_c0", idx), Stall, v.exp_align ? 32'd0 : 32'd1);
    if (v.exp_align) begin
      @(negedge Clk);
      clear_inputs();
      #1;
      chk($sformatf("v%0d align_err", idx), AlignErr, 1);
      chk($sformatf("v%0d align_noreq", idx), {Stall, DMemReq}, 0);
      return;
    end
    sb_q.push_back(v.exp_read);
    exp_stalls = (v.ack_at != 0) ? v.ack_at + 1 : TO + 2;
    stalls = 1;
    k = 0;
    done = 0;
    while (!done && k < TO + 4) begin
      @(negedge Clk);
      #1;
      k++;
      if (AccessDone) begin
        done = 1;
        clear_inputs();
      end else begin
        if (Stall) stalls++;
        if (k == 1) begin
          chk($sformatf("v%0d req", idx), DMemReq, 1);
          chk($sformatf("v%0d we", idx), DMemWe, v.exp_we);
          chk($sformatf("v%0d addr", idx), DMemAddr, v.exp_addr);
          chk($sformatf("v%0d be", idx), DMemBE, v.exp_be);
          chk($sformatf("v%0d wdata", idx), DMemWData, v.exp_wd);
        end
        DMemAck   = (k == v.ack_at);
        DMemRData = v.rdata;
      end
    end
    if (!done) begin
      chk($sformatf("v%0d done_wait", idx), 0, 1);
      clear_inputs();
      return;
    end
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d sb_empty", idx), 0, 1);
      exp_rd = '0;
    end else begin
      exp_rd = sb_q.pop_front();
    end
    chk($sformatf("v%0d rdata", idx), ReadData_out, exp_rd);
    chk($sformatf("v%0d done_stall", idx), {DMemReq, Stall}, 0);
    chk($sformatf("v%0d buserr", idx), BusErr, (v.ack_at == 0) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d stall_cycles", idx), stalls, exp_stalls);
    @(negedge Clk);
    #1;
    chk($sformatf("v%0d done_pulse", idx), {AccessDone, BusErr}, 0);
  endtask

  initial begin
    //        rd  wr  size   addr          wdata         rdata         ack align be       exp_wd        exp_addr      we  exp_read
    vecs.push_back('{0, 1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        2, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0010, 1, 32'h0000_0000});
    vecs.push_back('{1, 0, 2'b10, 32'h0000_0003, 32'h1234_5678, 32'h80FF_0011, 1, 0, 4'b1000, 32'h7878_7878, 32'h0000_0000, 0, 32'hFFFF_FF80});
    vecs.push_back('{1, 0, 2'b01, 32'h0000_0002, 32'hAAAA_5555, 32'h7FFF_8000, 3, 0, 4'b1100, 32'h5555_5555, 32'h0000_0000, 0, 32'h0000_7FFF});
    vecs.push_back('{1, 0, 2'b00, 32'h0000_0006, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0,         32'h0,         0, 32'h0});
    vecs.push_back('{0, 1, 2'b01, 32'h0000_0001, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0,         32'h0,         0, 32'h0});
    vecs.push_back('{0, 1, 2'b10, 32'h0000_0021, 32'h0000_00A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0020, 1, 32'h0000_7FFF});
    vecs.push_back('{1, 0, 2'b01, 32'h0000_0000, 32'h0,         32'h1234_8765, 1, 0, 4'b0011, 32'h0,         32'h0000_0000, 0, 32'hFFFF_8765});
    vecs.push_back('{1, 0, 2'b00, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 2, 0, 4'b1111, 32'h0,         32'h0000_0104, 0, 32'hCAFE_F00D});
    vecs.push_back('{1, 0, 2'b11, 32'h0000_0008, 32'h0,         32'h0102_0304, 1, 0, 4'b1111, 32'h0,         32'h0000_0008, 0, 32'h0102_0304});
    vecs.push_back('{1, 0, 2'b00, 32'h0000_0040, 32'h0,         32'h9999_9999, 0, 0, 4'b1111, 32'h0,         32'h0000_0040, 0, 32'h0102_0304});
    vecs.push_back('{1, 0, 2'b00, 32'h0000_0044, 32'h0,         32'h55AA_55AA, 16, 0, 4'b1111, 32'h0,        32'h0000_0044, 0, 32'h55AA_55AA});
    vecs.push_back('{1, 1, 2'b00, 32'h0000_0030, 32'h1122_3344, 32'hFFFF_FFFF, 1, 0, 4'b1111, 32'h1122_3344, 32'h0000_0030, 1, 32'h55AA_55AA});
    vecs.push_back('{1, 0, 2'b10, 32'h0000_0001, 32'h0,         32'h0000_7F00, 1, 0, 4'b0010, 32'h0,         32'h0000_0000, 0, 32'h0000_007F});

    clear_inputs();
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_outs", {Stall, AccessDone, AlignErr, BusErr, DMemReq, DMemWe, DMemBE}, 0);
    chk("reset_rdata", ReadData_out, 0);
    chk("reset_addr", DMemAddr, 0);
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset while a load is outstanding, then a stray ack after release
    @(negedge Clk);
    MemRead_in   = 1'b1;
    MuxLoad_in   = 2'b00;
    ALUResult_in = 32'h0000_0050;
    repeat (2) @(negedge Clk);
    #1;
    chk("midreq_req", {DMemReq, Stall}, 2'b11);
    Rst = 1'b0;
    #1;
    chk("midreq_rst_drop", {DMemReq, Stall}, 0);
    chk("midreq_rst_rdata", ReadData_out, 0);
    @(negedge Clk);
    clear_inputs();
    Rst = 1'b1;
    #1;
    DMemAck   = 1'b1;
    DMemRData = 32'hFFFF_FFFF;
    @(negedge Clk);
    #1;
    chk("stray_ack_c1", {AccessDone, DMemReq, Stall, BusErr}, 0);
    DMemAck = 1'b0;
    @(negedge Clk);
    #1;
    chk("stray_ack_c2", {AccessDone, DMemReq, Stall}, 0);
    chk("stray_ack_rdata", ReadData_out, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller. It consumes the memory-control, address and store-data outputs of the EX/MEM pipeline register and runs a request/acknowledge transaction on the data-memory bus. It stalls the upstream pipeline until the memory responds. It returns aligned, sign-extended load data toward the MEM/WB register.

## Interface
Parameters:
- TIMEOUT, 15: number of REQ cycles without DMemAck before the access is abandoned with BusErr.

Ports:
- Clk  in  1  clock; everything is sampled on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- MemRead_in  in  1  load request from EX/MEM.
- MemWrite_in  in  1  store request from EX/MEM.
- MuxLoad_in  in  2  access size: 00 word, 01 half, 10 byte; 11 is treated as word.
- ALUResult_in  in  32  byte address.
- Rt_in  in  32  store data.
- Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- ReadData_out  out  32  last completed load result; held until the next load completes.
- AccessDone  out  1  one-cycle pulse when a transaction completes.
- AlignErr  out  1  one-cycle pulse for a misaligned access.
- BusErr  out  1  one-cycle pulse on timeout.
- DMemReq  out  1  bus request.
- DMemWe  out  1  1 for a write.
- DMemAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- DMemBE  out  4  byte enables.
- DMemWData  out  32  lane-replicated store data.
- DMemAck  in  1  memory acknowledge; valid only while DMemReq=1.
- DMemRData  in  32  read word; valid with DMemAck.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, no access: remain in IDLE.
- IDLE, access (MemRead_in|MemWrite_in):
  - If both are high, the write wins.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. A misaligned access pulses AlignErr next cycle, issues no bus request, does not stall, and stays in IDLE.
  - An aligned access latches address, size, we and data, then goes to REQ.
- REQ: DMemReq=1, with addr/we/BE/wdata held stable.
  - On DMemAck, go to DONE. A load also captures the extracted data.
  - If the counter reaches TIMEOUT without an ack, go to DONE, pulse BusErr, and leave ReadData_out unchanged.
- DONE: AccessDone=1 for one cycle, then IDLE.
- Stall = (IDLE & access & aligned) | REQ. Stall is combinational and low in DONE, so EX/MEM advances at the end of DONE and the same instruction is never re-issued.
- Byte enables:
  - byte: BE=1<<addr[1:0], with the byte replicated ×4.
  - half: BE=addr[1]?1100:0011, with the half replicated ×2.
  - word: BE=1111.
- Load extraction: the byte lane addr[1:0] or half lane addr[1] is sign-extended to 32 bits; a word load passes through.
- DMemAck outside REQ is ignored.

## Timing
- Reset (Rst=0, asynchronous): state goes to IDLE and the timeout counter to 0. All outputs are 0, including ReadData_out, DMemReq, Stall, AccessDone, AlignErr and BusErr.
- Reset mid-REQ drops DMemReq immediately and abandons the transaction; a late ack is ignored.
- Access detected in cycle 0: Stall=1 in cycle 0, DMemReq=1 from cycle 1.
- Ack in cycle n≥1: DONE in cycle n+1, with AccessDone=1, Stall=0 and ReadData_out valid.
- Minimum stall is 2 cycles per access. Back-to-back accesses re-enter IDLE for one cycle between transactions.
- Timeout counter: 4 bits minimum, cleared on entry to REQ and incremented each REQ cycle without an ack. BusErr triggers when count==TIMEOUT.
- Ack in the same cycle the counter reaches TIMEOUT: the ack wins and BusErr is not asserted.
- Error outputs are registered one-cycle pulses.

## Structure
- Shared package/header mem_pkg holds:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state encodings S_IDLE, S_REQ, S_DONE.
- Sub-module mem_lane_align (combinational) holds the alignment check, BE/wdata generation and read-lane sign extension. It is instantiated once; the FSM, counter and registers live in mem_access_unit.

## Test plan
- Word store, addr 0x0000_0010, data 0xDEADBEEF, ack on the 2nd REQ cycle -> DMemBE=1111, DMemWe=1, Stall high for 3 cycles, one AccessDone pulse.
- Byte load, addr 0x0000_0003, DMemRData 0x80FF_0011 -> ReadData_out=0xFFFF_FF80.
- Half load, addr 0x0000_0002, rdata 0x7FFF_8000 -> ReadData_out=0x0000_7FFF, DMemAddr=0x0000_0000.
- Word load at addr 0x0000_0006 -> AlignErr pulse, DMemReq never asserted, Stall=0.
- No ack, TIMEOUT=15 -> BusErr at REQ count 15, ReadData_out unchanged. Repeat with ack exactly at count 15 -> no BusErr.
- Rst low during REQ -> DMemReq and Stall go to 0 asynchronously. After release, a stray ack produces no AccessDone.
